// File: rtl/wb_slave_mem_model.sv
// Wishbone-classic slave memory with byte-lane writes, window/alignment/sel errors and abortable wait states.
// Define WB_MEM_ERR_INJECT_EN to add an address-match error injection port pair.
module wb_slave_mem_model #(
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_MIN    = 0,
    parameter int ADDR_MAX    = 2048,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cycIn,
    input  logic                   stbIn,
    input  logic [31:0]            adrIn,
    input  logic [BUS_WIDTH/8-1:0] selIn,
    input  logic [BUS_WIDTH-1:0]   datIn,
    input  logic                   weIn,
`ifdef WB_MEM_ERR_INJECT_EN
    input  logic                   errInjectEnIn,
    input  logic [31:0]            errInjectAdrIn,
`endif
    output logic [BUS_WIDTH-1:0]   datOut,
    output logic                   ackOut,
    output logic                   errOut
);
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int DEPTH = (ADDR_MAX - ADDR_MIN) / BYTES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ADDR_MIN32 = 32'(ADDR_MIN);
    localparam logic [31:0] ADDR_MAX32 = 32'(ADDR_MAX);
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);
    localparam logic [3:0]  WS_LOAD    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           state;
    logic [3:0]           wait_cnt;
    logic [31:0]          lat_adr;
    logic [BYTES-1:0]     lat_sel;
    logic [BUS_WIDTH-1:0] lat_dat;
    logic                 lat_we;
    logic                 commit_ok;
    logic [IDX_W-1:0]     resp_idx;
    logic [BUS_WIDTH-1:0] mem [DEPTH];

    logic                 in_idle;
    logic                 req;
    logic                 go_resp;
    logic [31:0]          cur_adr;
    logic [BYTES-1:0]     cur_sel;
    logic                 cur_we;
    logic [32:0]          cur_off;
    logic                 cur_err;
    logic                 inject_hit;
    logic [IDX_W-1:0]     cur_idx;

    assign in_idle = (state == S_IDLE);
    assign req     = cycIn && stbIn && !ackOut && !errOut;

    // In IDLE the live bus is decoded so a zero-wait access can respond on its sampling edge.
    assign cur_adr = in_idle ? adrIn : lat_adr;
    assign cur_sel = in_idle ? selIn : lat_sel;
    assign cur_we  = in_idle ? weIn  : lat_we;

    // 33-bit subtraction: the borrow bit flags addresses below the window without wrapping.
    assign cur_off = {1'b0, cur_adr} - {1'b0, ADDR_MIN32};
    assign cur_idx = IDX_W'(cur_off[31:0] >> OFF_W);

`ifdef WB_MEM_ERR_INJECT_EN
    assign inject_hit = errInjectEnIn && (cur_adr == errInjectAdrIn);
`else
    assign inject_hit = 1'b0;
`endif

    assign cur_err = cur_off[32]
                  || (cur_adr >= ADDR_MAX32)
                  || ((cur_adr & ALIGN_MASK) != 32'd0)
                  || (cur_sel == '0)
                  || inject_hit;

    always_comb begin
        go_resp = 1'b0;
        case (state)
            S_IDLE:  go_resp = req && (WAIT_STATES == 0);
            S_WAIT:  go_resp = cycIn && stbIn && (wait_cnt == 4'd0);
            default: go_resp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            lat_adr   <= '0;
            lat_sel   <= '0;
            lat_dat   <= '0;
            lat_we    <= 1'b0;
            commit_ok <= 1'b0;
            resp_idx  <= '0;
            ackOut    <= 1'b0;
            errOut    <= 1'b0;
            datOut    <= '0;
        end else begin
            if (go_resp) begin
                ackOut    <= !cur_err;
                errOut    <= cur_err;
                commit_ok <= !cur_err && cur_we;
                resp_idx  <= cur_idx;
                datOut    <= (cur_err || cur_we) ? '0 : mem[cur_idx];
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_adr <= adrIn;
                        lat_sel <= selIn;
                        lat_dat <= datIn;
                        lat_we  <= weIn;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WS_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!(cycIn && stbIn)) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    ackOut    <= 1'b0;
                    errOut    <= 1'b0;
                    datOut    <= '0;
                    commit_ok <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write lands at the end of the response cycle, so a reset before then drops it.
    always_ff @(posedge clk) begin
        if ((state == S_RESP) && commit_ok) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lat_sel[i]) begin
                    mem[resp_idx][8*i +: 8] <= lat_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem_model.sv
// Bench for wb_slave_mem_model: a zero-wait and a three-wait instance, directed vectors plus random
// accesses against a per-instance word/byte-lane reference array.
module tb_wb_slave_mem_model;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [3:0]  sel   [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic        ack   [2];
    logic        err   [2];
`ifdef WB_MEM_ERR_INJECT_EN
    logic        inj_en  [2];
    logic [31:0] inj_adr [2];
`endif

    int checks   = 0;
    int failures = 0;

    wb_slave_mem_model #(.BUS_WIDTH(32), .ADDR_MIN(0), .ADDR_MAX(2048), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .cycIn(cyc[0]), .stbIn(stb[0]), .adrIn(adr[0]), .selIn(sel[0]),
        .datIn(dat_w[0]), .weIn(we[0]),
`ifdef WB_MEM_ERR_INJECT_EN
        .errInjectEnIn(inj_en[0]), .errInjectAdrIn(inj_adr[0]),
`endif
        .datOut(dat_r[0]), .ackOut(ack[0]), .errOut(err[0])
    );

    wb_slave_mem_model #(.BUS_WIDTH(32), .ADDR_MIN(0), .ADDR_MAX(2048), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .cycIn(cyc[1]), .stbIn(stb[1]), .adrIn(adr[1]), .selIn(sel[1]),
        .datIn(dat_w[1]), .weIn(we[1]),
`ifdef WB_MEM_ERR_INJECT_EN
        .errInjectEnIn(inj_en[1]), .errInjectAdrIn(inj_adr[1]),
`endif
        .datOut(dat_r[1]), .ackOut(ack[1]), .errOut(err[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete master access; lat counts rising edges from request drive to visible termination.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] wd, output bit got_ack, output bit got_err,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; dat_w[d] = wd;
        got_ack = 1'b0; got_err = 1'b0; rd = 32'd0; lat = 0;
        for (int i = 1; i <= 20 && !(got_ack || got_err); i++) begin
            @(posedge clk); #1;
            if (ack[d] || err[d]) begin
                got_ack = ack[d]; got_err = err[d]; rd = dat_r[d]; lat = i;
            end
        end
        @(negedge clk);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("pulse_end_d%0d", d), {ack[d], err[d], dat_r[d]}, 34'd0);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        bit          e;
        logic [31:0] r;
    } vec_t;

    vec_t        vt [14];
    logic [31:0] model [2][16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ga, ge, w, exp_err;
        logic [31:0] rd, a, v, exp_rd;
        logic [3:0]  s;
        int          lat, bad, d, kind, k;

        vt[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h0000_0010, 4'h5, 32'h1122_3344, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h0000_0010, 4'h1, 32'h0,         1'b0, 32'hDE22_BE44};
        vt[4]  = '{1'b0, 32'h0000_0800, 4'hF, 32'h0,         1'b1, 32'h0};
        vt[5]  = '{1'b0, 32'h0000_0002, 4'hF, 32'h0,         1'b1, 32'h0};
        vt[6]  = '{1'b1, 32'h0000_0800, 4'hF, 32'h0,         1'b1, 32'h0};
        vt[7]  = '{1'b1, 32'h0000_0012, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vt[8]  = '{1'b1, 32'h0000_0010, 4'h0, 32'h0,         1'b1, 32'h0};
        vt[9]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b0, 32'hDE22_BE44};
        vt[10] = '{1'b1, 32'h0000_07FC, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
        vt[11] = '{1'b0, 32'h0000_07FC, 4'h8, 32'h0,         1'b0, 32'hCAFE_F00D};
        vt[12] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         1'b1, 32'h0};
        vt[13] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 32'h0};

        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = 32'd0; sel[i] = 4'd0; dat_w[i] = 32'd0;
`ifdef WB_MEM_ERR_INJECT_EN
            inj_en[i] = 1'b0; inj_adr[i] = 32'd0;
`endif
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_outputs_d%0d", i), {ack[i], err[i], dat_r[i]}, 34'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            access(0, vt[i].w, vt[i].a, vt[i].s, vt[i].d, ga, ge, rd, lat);
            chk($sformatf("vec%0d_ack", i), ga, !vt[i].e);
            chk($sformatf("vec%0d_err", i), ge, vt[i].e);
            chk($sformatf("vec%0d_dat", i), rd, vt[i].r);
            chk($sformatf("vec%0d_lat", i), lat, 1);
        end

        // Back-to-back with stb held: write then read of the same word must return the new data.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h34; sel[0] = 4'hF; dat_w[0] = 32'h600D_CAFE;
        @(posedge clk); #1; chk("b2b_wr_ack", ack[0], 1);
        @(negedge clk); we[0] = 1'b0;
        @(posedge clk); #1; chk("b2b_gap", {ack[0], err[0]}, 0);
        @(posedge clk); #1; chk("b2b_rd_ack", ack[0], 1); chk("b2b_rd_dat", dat_r[0], 32'h600D_CAFE);
        @(negedge clk); cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1; chk("b2b_end", {ack[0], dat_r[0]}, 0);

        // Three wait states: latency, abort, and reset in the middle of a write.
        access(1, 1'b1, 32'h10, 4'hF, 32'hA5A5_A5A5, ga, ge, rd, lat);
        chk("ws3_wr_ack", ga, 1); chk("ws3_wr_lat", lat, 4);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, ga, ge, rd, lat);
        chk("ws3_rd_lat", lat, 4); chk("ws3_rd_dat", rd, 32'hA5A5_A5A5);

        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h10; sel[1] = 4'hF; dat_w[1] = 32'h5A5A_5A5A;
        repeat (2) @(posedge clk);
        @(negedge clk); stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) bad++;
        end
        chk("abort_no_resp", bad, 0);
        access(1, 1'b0, 32'h10, 4'hF, 32'h0, ga, ge, rd, lat);
        chk("abort_no_write", rd, 32'hA5A5_A5A5);

        access(1, 1'b1, 32'h20, 4'hF, 32'h1111_1111, ga, ge, rd, lat);
        chk("pre_rst_wr_ack", ga, 1);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; sel[1] = 4'hF; dat_w[1] = 32'h2222_2222;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1 chk("rst_mid_outputs", {ack[1], err[1], dat_r[1]}, 34'd0);
        @(negedge clk); rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) bad++;
        end
        chk("rst_no_resp", bad, 0);
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, ga, ge, rd, lat);
        chk("rst_write_dropped", rd, 32'h1111_1111);

`ifdef WB_MEM_ERR_INJECT_EN
        access(0, 1'b1, 32'h40, 4'hF, 32'h1357_9BDF, ga, ge, rd, lat);
        chk("inj_pre_ack", ga, 1);
        inj_adr[0] = 32'h40; inj_en[0] = 1'b1;
        access(0, 1'b1, 32'h40, 4'hF, 32'h2468_ACE0, ga, ge, rd, lat);
        chk("inj_err", {ga, ge}, 2'b01); chk("inj_lat", lat, 1);
        inj_en[0] = 1'b0;
        access(0, 1'b0, 32'h40, 4'hF, 32'h0, ga, ge, rd, lat);
        chk("inj_off_ack", {ga, ge}, 2'b10); chk("inj_old_data", rd, 32'h1357_9BDF);
`endif

        // Random accesses over a 16-word window, preloaded so every read has a known value.
        for (int di = 0; di < 2; di++) begin
            for (int ki = 0; ki < 16; ki++) begin
                v = $urandom;
                access(di, 1'b1, 32'(ki * 4), 4'hF, v, ga, ge, rd, lat);
                model[di][ki] = v;
                chk("preload_ack", ga, 1);
            end
        end
        for (int n = 0; n < 150; n++) begin
            d    = $urandom_range(0, 1);
            w    = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            k    = $urandom_range(0, 15);
            if (kind < 7)       a = 32'(k * 4);
            else if (kind == 7) a = 32'h800 + 32'(k * 4);
            else if (kind == 8) a = 32'(k * 4) + 32'($urandom_range(1, 3));
            else                a = 32'hFFFF_FFC0 + 32'(k * 4);
            s = 4'($urandom_range(0, 15));
            v = $urandom;
            exp_err = (a >= 32'd2048) || (a % 4 != 0) || (s == 4'd0);
            exp_rd  = (!exp_err && !w) ? model[d][k] : 32'd0;
            access(d, w, a, s, v, ga, ge, rd, lat);
            chk($sformatf("rnd%0d_resp a=%0h", n, a), {ga, ge}, {!exp_err, exp_err});
            chk($sformatf("rnd%0d_dat a=%0h", n, a), rd, exp_rd);
            chk($sformatf("rnd%0d_lat", n), lat, (d == 0) ? 1 : 4);
            if (!exp_err && w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[d][k][8*b +: 8] = v[8*b +: 8];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
